// File: rtl/instr_encode.sv
// instr_encode
//   Packs RV32I fields plus a 32-bit immediate into one instruction word per
//   input handshake. Each emitted word carries a sequential byte address.
//   Immediates that are out of range or misaligned are rejected and raise a
//   sticky error. A request with an illegal format is rejected the same way.
//
// Parameters
//   ADDR_W  width of out_addr
//   BASE    byte address of the first word after reset/start
//   DEPTH   maximum number of words per program
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               restart the program: address, count and error are cleared
//   in_valid/in_ready   request handshake
//   in_immsrc           000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 11x illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm  request fields
//   out_valid/out_ready output handshake
//   out_instr, out_addr encoded word and its byte address
//   word_count          words emitted since reset/start
//   done                DEPTH words emitted
//   err, err_code       sticky error and the code of the first error
//                       (01 range, 10 misaligned, 11 illegal immsrc)
module instr_encode #(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter int                DEPTH  = 64,
   localparam int               CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_immsrc,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [CW-1:0]     word_count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic {S_RUN, S_FULL} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_vld_p1;
   logic [31:0]         r_instr_p1;
   logic [ADDR_W-1:0]   r_addr;
   logic [CW-1:0]       r_count;
   logic                r_err;
   logic [1:0]          r_err_code;

   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_last_pending;
   logic [1:0]          w_code;
   logic [31:0]         w_instr;

   // Immediate legality: range is tested before alignment; 00 means accept.
   function automatic logic [1:0] imm_check(input logic [2:0] src,
                                            input logic signed [31:0] imm);
      logic [1:0] code;
      code = 2'b00;
      case (src)
         3'b000, 3'b001: begin
            if (imm < -32'sd2048 || imm > 32'sd2047) code = 2'b01;
         end
         3'b010: begin
            if (imm < -32'sd4096 || imm > 32'sd4094) code = 2'b01;
            else if (imm[0])                         code = 2'b10;
         end
         3'b011: begin
            if (imm < -32'sd1048576 || imm > 32'sd1048574) code = 2'b01;
            else if (imm[0])                               code = 2'b10;
         end
         3'b100: begin
            if (imm[11:0] != 12'd0) code = 2'b10;
         end
         3'b101:  code = 2'b00;
         default: code = 2'b11;
      endcase
      return code;
   endfunction

   function automatic logic [31:0] encode(input logic [2:0]  src,
                                          input logic [6:0]  op,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  rs1,
                                          input logic [4:0]  rs2,
                                          input logic [2:0]  f3,
                                          input logic [6:0]  f7,
                                          input logic [31:0] imm);
      logic [31:0] w;
      case (src)
         3'b000:  w = {imm[11:0], rs1, f3, rd, op};
         3'b001:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         3'b010:  w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         3'b011:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         3'b100:  w = {imm[31:12], rd, op};
         3'b101:  w = {f7, rs2, rs1, f3, rd, op};
         default: w = '0;
      endcase
      return w;
   endfunction

   assign w_code  = imm_check(in_immsrc, in_imm);
   assign w_instr = encode(in_immsrc, in_opcode, in_rd, in_rs1, in_rs2,
                           in_funct3, in_funct7, in_imm);

   // The DEPTH-th word is already sitting in the output register: take nothing
   // more, so no request is ever accepted beyond the program length.
   assign w_last_pending = r_vld_p1 && (r_count == CW'(DEPTH - 1));

   // start/reset win over a same-cycle request, so the request is not consumed.
   assign in_ready   = (r_state == S_RUN) && !start && !reset &&
                       (!r_vld_p1 || out_ready) && !w_last_pending;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_vld_p1 && out_ready;

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_RUN && w_out_fire && r_count == CW'(DEPTH - 1))
         w_state_next = S_FULL;
   end

   always_ff @(posedge clk) begin
      if (reset || start) r_state <= S_RUN;
      else                r_state <= w_state_next;
   end

   // ---- stage p1: encoded word register, address and count bookkeeping ----
   always_ff @(posedge clk) begin
      if (reset || start) begin
         r_vld_p1   <= 1'b0;
         r_instr_p1 <= '0;
         r_addr     <= BASE;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         // r_addr always labels the presented (or next) word, so it advances
         // only when a word leaves.
         if (w_out_fire) begin
            r_addr  <= r_addr + ADDR_W'(4);
            r_count <= r_count + CW'(1);
         end
         if (w_in_fire && w_code == 2'b00) begin
            r_vld_p1   <= 1'b1;
            r_instr_p1 <= w_instr;
         end else if (w_out_fire) begin
            r_vld_p1 <= 1'b0;
         end
         if (w_in_fire && w_code != 2'b00) begin
            r_err <= 1'b1;
            if (r_err_code == 2'b00) r_err_code <= w_code;
         end
      end
   end

   assign out_valid  = r_vld_p1;
   assign out_instr  = r_instr_p1;
   assign out_addr   = r_addr;
   assign word_count = r_count;
   assign done       = (r_state == S_FULL);
   assign err        = r_err;
   assign err_code   = r_err_code;

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;

   localparam logic [31:0] MBASE  = 32'h0000_0000;
   localparam int          MDEPTH = 64;
   localparam logic [31:0] FBASE  = 32'h0000_0100;
   localparam int          FDEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, in_valid, in_ready, out_valid, out_ready, done, err;
   logic [2:0]  in_immsrc, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm, out_instr, out_addr;
   logic [6:0]  word_count;
   logic [1:0]  err_code;

   logic        f_start, f_valid, f_in_ready, f_out_valid, f_oready, f_done, f_err;
   logic [31:0] f_out_instr, f_out_addr;
   logic [2:0]  f_word_count;
   logic [1:0]  f_err_code;

   instr_encode #(.ADDR_W(32), .BASE(MBASE), .DEPTH(MDEPTH)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .word_count(word_count), .done(done), .err(err),
      .err_code(err_code));

   instr_encode #(.ADDR_W(32), .BASE(FBASE), .DEPTH(FDEPTH)) u_full (
      .clk(clk), .reset(reset), .start(f_start), .in_valid(f_valid), .in_ready(f_in_ready),
      .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(f_out_valid), .out_ready(f_oready), .out_instr(f_out_instr),
      .out_addr(f_out_addr), .word_count(f_word_count), .done(f_done), .err(f_err),
      .err_code(f_err_code));

   typedef struct {
      logic [2:0]  src;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          imm;
      logic [31:0] addr;
      bit          chk_word;
      logic [31:0] word;
   } exp_t;

   exp_t q_main[$];
   exp_t q_full[$];

   int checks = 0;
   int errors = 0;
   int m_words = 0;
   logic       m_err = 1'b0;
   logic [1:0] m_code = 2'b00;
   int f_acc = 0;
   int f_seen = 0;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Legality rules written as plain integer arithmetic.
   function automatic logic [1:0] model_code(input logic [2:0] src, input int imm);
      case (src)
         3'd0, 3'd1: return (imm < -2048 || imm > 2047) ? 2'b01 : 2'b00;
         3'd2: begin
            if (imm < -4096 || imm > 4094) return 2'b01;
            if (imm % 2 != 0)              return 2'b10;
            return 2'b00;
         end
         3'd3: begin
            if (imm < -1048576 || imm > 1048574) return 2'b01;
            if (imm % 2 != 0)                    return 2'b10;
            return 2'b00;
         end
         3'd4:    return (imm % 4096 != 0) ? 2'b10 : 2'b00;
         3'd5:    return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   // The core's immediate extender: recovers the immediate from a word.
   function automatic int extend(input logic [2:0] src, input logic [31:0] w);
      logic [31:0] v;
      case (src)
         3'd0:    v = {{20{w[31]}}, w[31:20]};
         3'd1:    v = {{20{w[31]}}, w[31:25], w[11:7]};
         3'd2:    v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         3'd3:    v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         3'd4:    v = {w[31:12], 12'b0};
         default: v = 32'd0;
      endcase
      return int'(v);
   endfunction

   task automatic check_word(input string tag, input exp_t e,
                             input logic [31:0] w, input logic [31:0] a);
      check({tag, ".addr"}, a, e.addr);
      check({tag, ".opcode"}, {25'd0, w[6:0]}, {25'd0, e.op});
      if (e.src != 3'd1 && e.src != 3'd2) check({tag, ".rd"}, {27'd0, w[11:7]}, {27'd0, e.rd});
      if (e.src == 3'd0 || e.src == 3'd1 || e.src == 3'd2 || e.src == 3'd5) begin
         check({tag, ".rs1"}, {27'd0, w[19:15]}, {27'd0, e.rs1});
         check({tag, ".funct3"}, {29'd0, w[14:12]}, {29'd0, e.f3});
      end
      if (e.src == 3'd1 || e.src == 3'd2 || e.src == 3'd5)
         check({tag, ".rs2"}, {27'd0, w[24:20]}, {27'd0, e.rs2});
      if (e.src == 3'd5) check({tag, ".funct7"}, {25'd0, w[31:25]}, {25'd0, e.f7});
      else               check({tag, ".imm_roundtrip"}, extend(e.src, w), e.imm);
      if (e.chk_word) check({tag, ".word"}, w, e.word);
   endtask

   // output consumer for the main instance
   always @(negedge clk) begin
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // monitors: decide the handshake from values that stay put until the next posedge
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
         if (q_main.size() == 0) begin
            checks++; errors++;
            $display("FAIL main.extra_word actual=%h required=none", out_instr);
         end else begin
            e = q_main.pop_front();
            check_word("main", e, out_instr, out_addr);
         end
      end
   end

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (f_out_valid && f_oready) begin
         f_seen++;
         if (q_full.size() == 0) begin
            checks++; errors++;
            $display("FAIL full.extra_word actual=%h required=none", f_out_instr);
         end else begin
            e = q_full.pop_front();
            check_word("full", e, f_out_instr, f_out_addr);
         end
      end
   end

   task automatic set_fields(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input int imm);
      in_immsrc = src; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
   endtask

   function automatic exp_t mk_exp(input bit chk, input logic [31:0] word, input logic [31:0] addr);
      exp_t e;
      e.src = in_immsrc; e.op = in_opcode; e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2;
      e.f3 = in_funct3; e.f7 = in_funct7; e.imm = int'(in_imm);
      e.addr = addr; e.chk_word = chk; e.word = word;
      return e;
   endfunction

   // Issues one request on the main instance; returns just after the accepting edge
   // with in_valid still high so consecutive calls are back-to-back.
   task automatic send_main(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input int imm, input bit chk,
                            input logic [31:0] word);
      bit ok;
      logic [1:0] c;
      @(negedge clk);
      set_fields(src, op, rd, rs1, rs2, f3, f7, imm);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         #1;
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL main.accept_timeout actual=in_ready_low required=accept");
         in_valid = 1'b0;
         return;
      end
      c = model_code(src, imm);
      if (c == 2'b00) begin
         q_main.push_back(mk_exp(chk, word, MBASE + 32'(4 * m_words)));
         m_words++;
      end else begin
         if (m_code == 2'b00) m_code = c;
         m_err = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      #1 in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      rdy_mode = 0;
      idle(1);
      for (int t = 0; t < 200 && q_main.size() != 0; t++) @(negedge clk);
      check({tag, ".pending_words"}, q_main.size(), 0);
   endtask

   task automatic send_random();
      logic [2:0] src;
      int imm;
      if ($urandom_range(0, 9) == 0) begin
         src = 3'($urandom_range(0, 7));
         imm = int'($urandom);
      end else begin
         src = 3'($urandom_range(0, 5));
         case (src)
            3'd0, 3'd1: imm = int'($urandom_range(0, 4095)) - 2048;
            3'd2:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3'd3:       imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            3'd4:       imm = int'($urandom & 32'hFFFF_F000);
            default:    imm = int'($urandom);
         endcase
      end
      send_main(src, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), imm, 1'b0, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; f_start = 1'b0; f_valid = 1'b0;
      f_oready = 1'b1; out_ready = 1'b1;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("reset.out_valid", {31'd0, out_valid}, 32'd0);
      check("reset.out_instr", out_instr, 32'd0);
      check("reset.out_addr", out_addr, MBASE);
      check("reset.word_count", {25'd0, word_count}, 32'd0);
      check("reset.done", {31'd0, done}, 32'd0);
      check("reset.err", {30'd0, err_code, err}, 32'd0);
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);

      // addi x8,x9,12 with one-cycle latency
      send_main(3'd0, 7'b0010011, 5'd8, 5'd9, 5'd0, 3'd0, 7'd0, 12, 1'b1, 32'h00C48413);
      #1;
      check("lat.out_valid", {31'd0, out_valid}, 32'd1);
      check("lat.out_instr", out_instr, 32'h00C48413);
      check("lat.out_addr", out_addr, MBASE);
      idle(2);

      // sw / beq / jal back to back
      send_main(3'd1, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 8, 1'b1, 32'h00512423);
      send_main(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -4, 1'b1, 32'hFE000EE3);
      send_main(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b1, 32'h001000EF);
      drain("b2b");

      // errors: range first, then misaligned must not overwrite the code
      send_main(3'd0, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048, 1'b0, 32'd0);
      #1;
      check("err.no_word", {31'd0, out_valid}, 32'd0);
      check("err.flag", {31'd0, err}, {31'd0, m_err});
      check("err.code_range", {30'd0, err_code}, {30'd0, m_code});
      idle(1);
      send_main(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3, 1'b0, 32'd0);
      #1;
      check("err.code_kept", {30'd0, err_code}, 32'd1);
      send_main(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123451B7);
      drain("after_err");

      // backpressure: stalled consumer holds the word and blocks input
      rdy_mode = 2;
      idle(2);
      send_main(3'd0, 7'b0010011, 5'd8, 5'd9, 5'd0, 3'd0, 7'd0, 12, 1'b1, 32'h00C48413);
      idle(0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #2;
         check("bp.in_ready", {31'd0, in_ready}, 32'd0);
         check("bp.out_instr", out_instr, 32'h00C48413);
      end
      rdy_mode = 1;
      for (int k = 0; k < 8; k++) send_random();
      drain("bp_release");
      check("bp.word_count", {25'd0, word_count}, 32'(m_words));

      // restart and a randomized program
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_words = 0; m_err = 1'b0; m_code = 2'b00;
      #2;
      check("start.out_addr", out_addr, MBASE);
      check("start.word_count", {25'd0, word_count}, 32'd0);
      check("start.err", {30'd0, err_code, err}, 32'd0);
      check("start.out_valid", {31'd0, out_valid}, 32'd0);
      rdy_mode = 1;
      for (int k = 0; k < 50; k++) send_random();
      drain("random");
      check("rand.word_count", {25'd0, word_count}, 32'(m_words));
      check("rand.err", {31'd0, err}, {31'd0, m_err});
      check("rand.err_code", {30'd0, err_code}, {30'd0, m_code});
      check("rand.done", {31'd0, done}, 32'd0);

      // DEPTH=4 instance: six requests, only four words
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         set_fields(3'd0, 7'b0010011, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, k * 3);
         f_valid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 8; t++) begin
            #1;
            if (f_in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
         end
         if (ok) begin
            q_full.push_back(mk_exp(1'b0, 32'd0, FBASE + 32'(4 * f_acc)));
            f_acc++;
            @(posedge clk);
         end
         #1 f_valid = 1'b0;
      end
      repeat (3) @(negedge clk);
      #3;
      check("full.accepted", f_acc, 4);
      check("full.words", f_seen, 4);
      check("full.done", {31'd0, f_done}, 32'd1);
      check("full.in_ready", {31'd0, f_in_ready}, 32'd0);
      check("full.word_count", {29'd0, f_word_count}, 32'd4);

      @(negedge clk);
      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      #2;
      check("full.start_addr", f_out_addr, FBASE);
      check("full.start_count", {29'd0, f_word_count}, 32'd0);
      check("full.start_done", {31'd0, f_done}, 32'd0);
      check("full.start_in_ready", {31'd0, f_in_ready}, 32'd1);
      @(negedge clk);
      set_fields(3'd0, 7'b0010011, 5'd8, 5'd9, 5'd0, 3'd0, 7'd0, 12);
      f_valid = 1'b1;
      #1;
      check("full.restart_accept", {31'd0, f_in_ready}, 32'd1);
      if (f_in_ready) q_full.push_back(mk_exp(1'b1, 32'h00C48413, FBASE));
      @(posedge clk);
      #1 f_valid = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("full.restart_words", f_seen, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
